// File: rtl/lgs_pkg.sv
// Shared definitions for the Costas-loop gain scheduler: state encodings,
// lock-metric width and the default gain shift amounts for each bandwidth.
package lgs_pkg;

   typedef enum logic [1:0] {
      ST_ACQ  = 2'd0,
      ST_PULL = 2'd1,
      ST_TRK  = 2'd2
   } lgs_state_t;

   localparam int MET_W    = 16;
   localparam int DEF_PD_W = 26;

   localparam logic [3:0] DEF_ACQ_C1  = 4'd4;
   localparam logic [4:0] DEF_ACQ_C2  = 5'd10;
   localparam logic [3:0] DEF_PULL_C1 = 4'd5;
   localparam logic [4:0] DEF_PULL_C2 = 5'd11;
   localparam logic [3:0] DEF_TRK_C1  = 4'd6;
   localparam logic [4:0] DEF_TRK_C2  = 5'd13;

endpackage

// File: rtl/loop_gain_scheduler_if.sv
// Bundle between phase detector / loop filter and the gain scheduler.
// master: the surrounding loop (drives pd, force_acq); slave: the scheduler.
interface loop_gain_scheduler_if
   import lgs_pkg::*;
#(
   parameter int PD_W = DEF_PD_W
) ();

   logic signed [PD_W-1:0] pd;
   logic                   force_acq;
   logic                   acc_en;
   logic                   upd_en;
   logic [3:0]             c1_shift;
   logic [4:0]             c2_shift;
   logic [1:0]             state;
   logic                   lock;
   logic [7:0]             lost_cnt;

   modport master (
      output pd, force_acq,
      input  acc_en, upd_en, c1_shift, c2_shift, state, lock, lost_cnt
   );

   modport slave (
      input  pd, force_acq,
      output acc_en, upd_en, c1_shift, c2_shift, state, lock, lost_cnt
   );

endinterface

// File: rtl/lgs_lock_metric.sv
// Lock metric: saturated |pd| scaled to 16 bits, summed over a window of
// 2^WIN_LOG2 samples; at the last sample the window mean is classified as
// good (below LOCK_TH), bad (above UNLOCK_TH) or in the hold band.
module lgs_lock_metric
   import lgs_pkg::*;
#(
   parameter int          PD_W      = DEF_PD_W,
   parameter int          WIN_LOG2  = 6,
   parameter logic [15:0] LOCK_TH   = 16'd512,
   parameter logic [15:0] UNLOCK_TH = 16'd2048
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic signed [PD_W-1:0] pd,
   input  logic                   sample,
   input  logic                   clr,
   output logic                   win_end,
   output logic                   good,
   output logic                   bad
);

   localparam int ACC_W = MET_W + WIN_LOG2;
   localparam logic [PD_W-1:0] PD_MIN = {1'b1, {(PD_W-1){1'b0}}};
   localparam logic [PD_W-1:0] PD_MAX = {1'b0, {(PD_W-1){1'b1}}};

   logic [MET_W-1:0]    mag;
   logic [ACC_W-1:0]    acc_q;
   logic [ACC_W-1:0]    sum;
   logic [MET_W-1:0]    mean;
   logic [WIN_LOG2-1:0] win_q;

   // The most negative code has no positive twin, so it is pinned to full scale
   // instead of wrapping back to itself.
   function automatic logic [MET_W-1:0] pd_mag(input logic [PD_W-1:0] v);
      logic [PD_W-1:0] a;
      if (v == PD_MIN)
         a = PD_MAX;
      else if (v[PD_W-1])
         a = -v;
      else
         a = v;
      return a[PD_W-2 -: MET_W];
   endfunction

   // Magnitude, running sum including the current sample, and window mean.
   always_comb begin
      mag     = pd_mag(pd);
      sum     = acc_q + ACC_W'(mag);
      mean    = sum[ACC_W-1 -: MET_W];
      win_end = sample && (win_q == '1);
      good    = mean < LOCK_TH;
      bad     = mean > UNLOCK_TH;
   end

   // Window accumulator; a clear request outranks a sample in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         win_q <= '0;
      end else if (clr) begin
         acc_q <= '0;
         win_q <= '0;
      end else if (sample) begin
         acc_q <= win_end ? '0 : sum;
         win_q <= win_q + WIN_LOG2'(1);
      end
   end

endmodule

// File: rtl/loop_gain_scheduler.sv
// Costas-loop gain scheduler: strobe generation for the second-order loop
// filter and ACQ -> PULL -> TRK bandwidth scheduling from the lock metric.
// Optional build macro LGS_LOST_CNT_EN adds a saturating lock-loss counter;
// without it lost_cnt is tied to zero.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_ACQ  | wide bandwidth, waiting for LOCK_WINS good windows
//   ST_PULL | medium bandwidth, bad window drops back to ACQ
//   ST_TRK  | narrow bandwidth, UNLOCK_WINS bad windows drop to ACQ
module loop_gain_scheduler
   import lgs_pkg::*;
#(
   parameter int          PD_W        = DEF_PD_W,
   parameter int          UPD_PERIOD  = 8,
   parameter int          WIN_LOG2    = 6,
   parameter logic [15:0] LOCK_TH     = 16'd512,
   parameter logic [15:0] UNLOCK_TH   = 16'd2048,
   parameter int          LOCK_WINS   = 4,
   parameter int          UNLOCK_WINS = 2,
   parameter logic [3:0]  ACQ_C1      = DEF_ACQ_C1,
   parameter logic [4:0]  ACQ_C2      = DEF_ACQ_C2,
   parameter logic [3:0]  PULL_C1     = DEF_PULL_C1,
   parameter logic [4:0]  PULL_C2     = DEF_PULL_C2,
   parameter logic [3:0]  TRK_C1      = DEF_TRK_C1,
   parameter logic [4:0]  TRK_C2      = DEF_TRK_C2
) (
   input  logic                  clk,
   input  logic                  rst,
   loop_gain_scheduler_if.slave  bus
);

   localparam int CNT_W = (UPD_PERIOD > 1) ? $clog2(UPD_PERIOD) : 1;
   localparam int GC_W  = $clog2(LOCK_WINS + 1);
   localparam int BC_W  = $clog2(UNLOCK_WINS + 1);

   logic [CNT_W-1:0] cnt_q;
   lgs_state_t       state_q, state_d;
   logic [GC_W-1:0]  good_q, good_d;
   logic [BC_W-1:0]  bad_q, bad_d;
   logic [3:0]       c1_q, c1_d;
   logic [4:0]       c2_q, c2_d;
   logic             acc_en;
   logic             win_end, win_good, win_bad;
`ifdef LGS_LOST_CNT_EN
   logic             lost_inc;
   logic [7:0]       lost_q;
`endif

   assign acc_en = (cnt_q == '0);

   lgs_lock_metric #(
      .PD_W      (PD_W),
      .WIN_LOG2  (WIN_LOG2),
      .LOCK_TH   (LOCK_TH),
      .UNLOCK_TH (UNLOCK_TH)
   ) u_metric (
      .clk     (clk),
      .rst     (rst),
      .pd      (bus.pd),
      .sample  (acc_en),
      .clr     (bus.force_acq),
      .win_end (win_end),
      .good    (win_good),
      .bad     (win_bad)
   );

   // Free-running period counter; force_acq deliberately leaves it alone so
   // the filter strobe cadence never slips.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + CNT_W'(1);
   end

   // Next-state logic: window-end decisions, with force_acq taking priority.
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      bad_d   = bad_q;
`ifdef LGS_LOST_CNT_EN
      lost_inc = 1'b0;
`endif
      if (bus.force_acq) begin
         state_d = ST_ACQ;
         good_d  = '0;
         bad_d   = '0;
      end else if (win_end) begin
         unique case (state_q)
            ST_ACQ: begin
               if (!win_good)
                  good_d = '0;
               else if (good_q == GC_W'(LOCK_WINS - 1)) begin
                  state_d = ST_PULL;
                  good_d  = '0;
               end else
                  good_d = good_q + GC_W'(1);
            end
            ST_PULL: begin
               if (win_bad) begin
                  state_d = ST_ACQ;
                  good_d  = '0;
               end else if (!win_good)
                  good_d = '0;
               else if (good_q == GC_W'(LOCK_WINS - 1)) begin
                  state_d = ST_TRK;
                  good_d  = '0;
               end else
                  good_d = good_q + GC_W'(1);
            end
            ST_TRK: begin
               if (!win_bad)
                  bad_d = '0;
               else if (bad_q == BC_W'(UNLOCK_WINS - 1)) begin
                  state_d = ST_ACQ;
                  bad_d   = '0;
`ifdef LGS_LOST_CNT_EN
                  lost_inc = 1'b1;
`endif
               end else
                  bad_d = bad_q + BC_W'(1);
            end
            default: begin
               state_d = ST_ACQ;
               good_d  = '0;
               bad_d   = '0;
            end
         endcase
      end
   end

   // Shifts are decoded from the next state so they change in the same cycle
   // as the state register.
   always_comb begin
      c1_d = ACQ_C1;
      c2_d = ACQ_C2;
      case (state_d)
         ST_PULL: begin
            c1_d = PULL_C1;
            c2_d = PULL_C2;
         end
         ST_TRK: begin
            c1_d = TRK_C1;
            c2_d = TRK_C2;
         end
         default: ;
      endcase
   end

   // State, window counters and registered gain shifts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_ACQ;
         good_q  <= '0;
         bad_q   <= '0;
         c1_q    <= ACQ_C1;
         c2_q    <= ACQ_C2;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         c1_q    <= c1_d;
         c2_q    <= c2_d;
      end
   end

`ifdef LGS_LOST_CNT_EN
   // Count TRK losses caused by bad windows; sticks at full scale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lost_q <= '0;
      else if (lost_inc && (lost_q != 8'hFF))
         lost_q <= lost_q + 8'd1;
   end
   assign bus.lost_cnt = lost_q;
`else
   assign bus.lost_cnt = 8'd0;
`endif

   assign bus.acc_en   = acc_en;
   assign bus.upd_en   = (cnt_q == CNT_W'(1));
   assign bus.c1_shift = c1_q;
   assign bus.c2_shift = c2_q;
   assign bus.state    = state_q;
   assign bus.lock     = (state_q == ST_TRK);

endmodule

// File: tb/tb_loop_gain_scheduler.sv
// Directed bench for loop_gain_scheduler with default parameters.
// Clock index k counts cycles since reset release; sampling is on the
// falling edge, where k names the cycle currently being presented.
// A window whose last sample is in cycle 512n-8 shows its decision at 512n-7.
`timescale 1ns/1ps
module tb_loop_gain_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   k = 0;
   logic [7:0] lost_exp;

   localparam logic signed [25:0] PD_HOLD = 26'sh0100000;  // mean 2048
   localparam logic signed [25:0] PD_BAD  = 26'sh0200000;  // mean 4096
   localparam logic signed [25:0] PD_BADN = -26'sh0200000;
   localparam logic signed [25:0] PD_MINV = 26'sh2000000;  // -2^25

   loop_gain_scheduler_if #(.PD_W(26)) bus ();

   loop_gain_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
      k++;
   endtask

   task automatic run_to(input int t);
      while (k < t) step();
   endtask

   task automatic do_reset();
      bus.pd = '0;
      bus.force_acq = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      #1;
   endtask

   task automatic test_reset();
      bus.pd = '0;
      bus.force_acq = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", bus.state); end
      tests++; if (bus.c1_shift !== 4'd4) begin fails++; $display("FAIL reset_c1 got %0d exp 4", bus.c1_shift); end
      tests++; if (bus.c2_shift !== 5'd10) begin fails++; $display("FAIL reset_c2 got %0d exp 10", bus.c2_shift); end
      tests++; if (bus.lock !== 1'b0) begin fails++; $display("FAIL reset_lock got %b exp 0", bus.lock); end
      tests++; if (bus.lost_cnt !== 8'd0) begin fails++; $display("FAIL reset_lost got %0d exp 0", bus.lost_cnt); end
   endtask

   task automatic test_strobes();
      do_reset();
      for (int i = 0; i < 32; i++) begin
         tests++; if (bus.acc_en !== ((i % 8) == 0)) begin fails++; $display("FAIL strobe_acc k=%0d got %b exp %b", k, bus.acc_en, (i % 8) == 0); end
         tests++; if (bus.upd_en !== ((i % 8) == 1)) begin fails++; $display("FAIL strobe_upd k=%0d got %b exp %b", k, bus.upd_en, (i % 8) == 1); end
         tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL strobe_state k=%0d got %0d exp 0", k, bus.state); end
         tests++; if ({bus.c1_shift, bus.c2_shift} !== {4'd4, 5'd10}) begin fails++; $display("FAIL strobe_shift k=%0d got %0d/%0d exp 4/10", k, bus.c1_shift, bus.c2_shift); end
         step();
      end
   endtask

   task automatic test_acquire();
      do_reset();
      run_to(2040);
      tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL acq_before_pull got %0d exp 0", bus.state); end
      step();
      tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL acq_to_pull got %0d exp 1", bus.state); end
      tests++; if ({bus.c1_shift, bus.c2_shift} !== {4'd5, 5'd11}) begin fails++; $display("FAIL pull_shift got %0d/%0d exp 5/11", bus.c1_shift, bus.c2_shift); end
      tests++; if (bus.upd_en !== 1'b1) begin fails++; $display("FAIL pull_on_upd got %b exp 1", bus.upd_en); end
      run_to(4088);
      tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL pull_before_trk got %0d exp 1", bus.state); end
      step();
      tests++; if (bus.state !== 2'd2) begin fails++; $display("FAIL pull_to_trk got %0d exp 2", bus.state); end
      tests++; if (bus.lock !== 1'b1) begin fails++; $display("FAIL trk_lock got %b exp 1", bus.lock); end
      tests++; if ({bus.c1_shift, bus.c2_shift} !== {4'd6, 5'd13}) begin fails++; $display("FAIL trk_shift got %0d/%0d exp 6/13", bus.c1_shift, bus.c2_shift); end
   endtask

   // Continues from TRK at k=4089.
   task automatic test_trk_loss();
      bus.pd = PD_HOLD;
      run_to(5113);
      tests++; if (bus.state !== 2'd2) begin fails++; $display("FAIL trk_hold_band got %0d exp 2", bus.state); end
      bus.pd = PD_BADN;
      run_to(5625);
      tests++; if (bus.state !== 2'd2) begin fails++; $display("FAIL trk_one_bad got %0d exp 2", bus.state); end
      run_to(6136);
      tests++; if (bus.state !== 2'd2) begin fails++; $display("FAIL trk_before_loss got %0d exp 2", bus.state); end
      step();
      tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL trk_loss got %0d exp 0", bus.state); end
      tests++; if (bus.lock !== 1'b0) begin fails++; $display("FAIL trk_loss_lock got %b exp 0", bus.lock); end
      tests++; if ({bus.c1_shift, bus.c2_shift} !== {4'd4, 5'd10}) begin fails++; $display("FAIL trk_loss_shift got %0d/%0d exp 4/10", bus.c1_shift, bus.c2_shift); end
      tests++; if (bus.lost_cnt !== lost_exp) begin fails++; $display("FAIL trk_loss_lost got %0d exp %0d", bus.lost_cnt, lost_exp); end
   endtask

   task automatic test_pull_bad();
      do_reset();
      run_to(2041);
      tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL pb_pull got %0d exp 1", bus.state); end
      bus.pd = PD_BAD;
      run_to(2552);
      tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL pb_before got %0d exp 1", bus.state); end
      step();
      tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL pb_to_acq got %0d exp 0", bus.state); end
      tests++; if (bus.c1_shift !== 4'd4) begin fails++; $display("FAIL pb_c1 got %0d exp 4", bus.c1_shift); end
      bus.pd = '0;
      run_to(3577);
      bus.pd = PD_HOLD;
      run_to(4089);
      bus.pd = '0;
      run_to(5113);
      tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL acq_hold_clears got %0d exp 0", bus.state); end
      run_to(6136);
      tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL acq_regood_before got %0d exp 0", bus.state); end
      step();
      tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL acq_regood_pull got %0d exp 1", bus.state); end
   endtask

   task automatic test_saturate();
      do_reset();
      run_to(2041);
      bus.pd = PD_MINV;
      run_to(2552);
      tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL sat_before got %0d exp 1", bus.state); end
      step();
      tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL sat_bad got %0d exp 0", bus.state); end
   endtask

   task automatic test_force();
      do_reset();
      run_to(4089);
      tests++; if (bus.state !== 2'd2) begin fails++; $display("FAIL f_trk got %0d exp 2", bus.state); end
      run_to(4600);
      tests++; if (bus.acc_en !== 1'b1) begin fails++; $display("FAIL f_at_win_end got %b exp 1", bus.acc_en); end
      bus.force_acq = 1'b1;
      step();
      bus.force_acq = 1'b0;
      tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL f_to_acq got %0d exp 0", bus.state); end
      tests++; if (bus.lock !== 1'b0) begin fails++; $display("FAIL f_lock got %b exp 0", bus.lock); end
      tests++; if ({bus.c1_shift, bus.c2_shift} !== {4'd4, 5'd10}) begin fails++; $display("FAIL f_shift got %0d/%0d exp 4/10", bus.c1_shift, bus.c2_shift); end
      tests++; if (bus.upd_en !== 1'b1) begin fails++; $display("FAIL f_upd_cadence got %b exp 1", bus.upd_en); end
      tests++; if (bus.lost_cnt !== 8'd0) begin fails++; $display("FAIL f_lost got %0d exp 0", bus.lost_cnt); end
      run_to(4607);
      tests++; if (bus.acc_en !== 1'b0) begin fails++; $display("FAIL f_acc_quiet got %b exp 0", bus.acc_en); end
      step();
      tests++; if (bus.acc_en !== 1'b1) begin fails++; $display("FAIL f_acc_cadence got %b exp 1", bus.acc_en); end
      run_to(6648);
      tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL f_repull_before got %0d exp 0", bus.state); end
      step();
      tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL f_repull got %0d exp 1", bus.state); end
      run_to(6900);
      bus.force_acq = 1'b1;
      step();
      tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL f_pull_force got %0d exp 0", bus.state); end
      run_to(7000);
      tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL f_held got %0d exp 0", bus.state); end
      run_to(7500);
      bus.force_acq = 1'b0;
      run_to(9544);
      tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL f_held_clear_before got %0d exp 0", bus.state); end
      step();
      tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL f_held_clear_pull got %0d exp 1", bus.state); end
   endtask

   task automatic test_async_reset();
      do_reset();
      run_to(2041);
      #2;
      rst = 1'b1;
      #1;
      tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL ar_state got %0d exp 0", bus.state); end
      tests++; if ({bus.c1_shift, bus.c2_shift} !== {4'd4, 5'd10}) begin fails++; $display("FAIL ar_shift got %0d/%0d exp 4/10", bus.c1_shift, bus.c2_shift); end
      tests++; if (bus.acc_en !== 1'b1) begin fails++; $display("FAIL ar_acc got %b exp 1", bus.acc_en); end
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      #1;
      run_to(2040);
      tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL ar_restart_before got %0d exp 0", bus.state); end
      step();
      tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL ar_restart_pull got %0d exp 1", bus.state); end
   endtask

   initial begin
`ifdef LGS_LOST_CNT_EN
      lost_exp = 8'd1;
`else
      lost_exp = 8'd0;
`endif
      test_reset();
      test_strobes();
      test_acquire();
      test_trk_loss();
      test_pull_bad();
      test_saturate();
      test_force();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
